// File: rtl/clip_outcode_pkg.sv
// -----------------------------------------------------------------------------
// clip_outcode_pkg
// Shared definitions for the 2D clipping stage: the screen-space point type,
// the Cohen-Sutherland outcode bit constants (also used by the line clipper)
// and small helpers for trivial accept/reject decisions on outcodes.
// -----------------------------------------------------------------------------
package clip_outcode_pkg;

  // Screen-space point, two's complement coordinates.
  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
  } Point2D;

  // Outcode bit layout: {TOP, BOTTOM, RIGHT, LEFT}.
  localparam logic [3:0] OC_INSIDE = 4'b0000;
  localparam logic [3:0] OC_LEFT   = 4'b0001;
  localparam logic [3:0] OC_RIGHT  = 4'b0010;
  localparam logic [3:0] OC_BOTTOM = 4'b0100;
  localparam logic [3:0] OC_TOP    = 4'b1000;

  // Default clip window, edges inclusive.
  localparam int CLIP_XMIN = 0;
  localparam int CLIP_XMAX = 640;
  localparam int CLIP_YMIN = 0;
  localparam int CLIP_YMAX = 480;

  // Both endpoints inside the window: the segment needs no clipping.
  function automatic logic oc_trivial_accept(input logic [3:0] a, input logic [3:0] b);
    return ((a | b) == OC_INSIDE);
  endfunction

  // Both endpoints beyond the same edge: the segment is entirely outside.
  function automatic logic oc_trivial_reject(input logic [3:0] a, input logic [3:0] b);
    return ((a & b) != OC_INSIDE);
  endfunction

endpackage

// File: rtl/clip_outcode_if.sv
// -----------------------------------------------------------------------------
// clip_outcode_if
// Point-in / outcode-out bundle for the classifier.
//   p    : point to classify (driven by the master, sampled every clock)
//   code : registered outcode for the point sampled on the previous edge
// -----------------------------------------------------------------------------
interface clip_outcode_if;
  import clip_outcode_pkg::*;

  Point2D     p;
  logic [3:0] code;

  modport master (output p, input code);
  modport slave  (input p, output code);

endinterface

// File: rtl/clip_outcode_axis.sv
// -----------------------------------------------------------------------------
// clip_outcode_axis
// Combinational single-axis classifier against an inclusive [lo..hi] range.
//   i_v     : coordinate value (signed)
//   i_lo    : lower inclusive bound (signed)
//   i_hi    : upper inclusive bound (signed)
//   o_above : i_v > i_hi (never set together with o_below)
//   o_below : i_v < i_lo
// -----------------------------------------------------------------------------
module clip_outcode_axis (
  input  logic signed [15:0] i_v,
  input  logic signed [15:0] i_lo,
  input  logic signed [15:0] i_hi,
  output logic               o_above,
  output logic               o_below
);

  logic w_below;

  // Strict signed compares: a value on either bound counts as inside.
  // "below" wins so the two flags stay exclusive even for a degenerate range.
  always_comb begin
    w_below = 1'b0;
    o_above = 1'b0;
    if (i_v < i_lo) begin
      w_below = 1'b1;
    end else begin
      w_below = 1'b0;
    end
    if ((i_v > i_hi) && !w_below) begin
      o_above = 1'b1;
    end else begin
      o_above = 1'b0;
    end
  end

  assign o_below = w_below;

endmodule

// File: rtl/clip_outcode.sv
// -----------------------------------------------------------------------------
// clip_outcode
// Cohen-Sutherland region classifier. Each clock the point on bus.p is
// compared against the fixed window [XMIN..XMAX]x[YMIN..YMAX] and the 4-bit
// outcode {TOP, BOTTOM, RIGHT, LEFT} appears on bus.code one cycle later.
//   clk      : system clock, rising edge
//   rst      : asynchronous, active-high; clears the outcode immediately
//   bus.p    : point to classify (new point accepted every cycle)
//   bus.code : registered outcode
// Window bounds must satisfy XMIN<=XMAX, YMIN<=YMAX and fit in signed 16 bits.
// -----------------------------------------------------------------------------
module clip_outcode
  import clip_outcode_pkg::*;
#(
  parameter int XMIN = CLIP_XMIN,
  parameter int XMAX = CLIP_XMAX,
  parameter int YMIN = CLIP_YMIN,
  parameter int YMAX = CLIP_YMAX
) (
  input  logic          clk,
  input  logic          rst,
  clip_outcode_if.slave bus
);

  localparam logic signed [15:0] XMIN_S = 16'(XMIN);
  localparam logic signed [15:0] XMAX_S = 16'(XMAX);
  localparam logic signed [15:0] YMIN_S = 16'(YMIN);
  localparam logic signed [15:0] YMAX_S = 16'(YMAX);

  logic       w_x_above;
  logic       w_x_below;
  logic       w_y_above;
  logic       w_y_below;
  logic [3:0] w_code;
  logic [3:0] r_code;

  // X axis: below the window is LEFT, above it is RIGHT.
  clip_outcode_axis u_axis_x (
    .i_v     (bus.p.x),
    .i_lo    (XMIN_S),
    .i_hi    (XMAX_S),
    .o_above (w_x_above),
    .o_below (w_x_below)
  );

  // Y axis: below the window is BOTTOM, above it is TOP.
  clip_outcode_axis u_axis_y (
    .i_v     (bus.p.y),
    .i_lo    (YMIN_S),
    .i_hi    (YMAX_S),
    .o_above (w_y_above),
    .o_below (w_y_below)
  );

  // Axis flags land directly on their outcode bit positions.
  assign w_code = {w_y_above, w_y_below, w_x_above, w_x_below};

  // Outcode register; reset clears it without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_code <= OC_INSIDE;
    end else begin
      r_code <= w_code;
    end
  end

  assign bus.code = r_code;

endmodule

// File: tb/tb_clip_outcode.sv
// -----------------------------------------------------------------------------
// tb_clip_outcode
// Scoreboard bench: the driver applies a point on the falling edge and queues
// the expected outcode; the monitor pops one entry after each rising edge
// (while out of reset) and compares it with the DUT output.
// -----------------------------------------------------------------------------
module tb_clip_outcode;
  import clip_outcode_pkg::*;

  localparam int XMIN = 0;
  localparam int XMAX = 640;
  localparam int YMIN = 0;
  localparam int YMAX = 480;

  logic clk;
  logic rst;
  clip_outcode_if bus ();

  clip_outcode #(
    .XMIN (XMIN),
    .XMAX (XMAX),
    .YMIN (YMIN),
    .YMAX (YMAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] exp_q[$];

  typedef struct {
    int         x;
    int         y;
    logic [3:0] e;
  } vec_t;

  // Grid, inclusive edges, just-outside edges, extremes.
  vec_t dir_tab [23] = '{
    '{-100, 560, 4'b1001}, '{300, 560, 4'b1000}, '{750, 560, 4'b1010},
    '{-100, 300, 4'b0001}, '{300, 300, 4'b0000}, '{750, 300, 4'b0010},
    '{-100, -100, 4'b0101}, '{300, -100, 4'b0100}, '{750, -100, 4'b0110},
    '{0, 0, 4'b0000}, '{640, 480, 4'b0000}, '{0, 480, 4'b0000}, '{640, 0, 4'b0000},
    '{-1, 0, 4'b0001}, '{641, 0, 4'b0010}, '{0, -1, 4'b0100}, '{0, 481, 4'b1000},
    '{-32768, 32767, 4'b1001}, '{32767, -32768, 4'b0110},
    '{300, 300, 4'b0000}, '{750, 560, 4'b1010}, '{300, 300, 4'b0000}, '{750, 560, 4'b1010}
  };

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: region test with plain integer arithmetic on the window.
  function automatic logic [3:0] ref_code(input int x, input int y);
    logic [3:0] c;
    c = 4'b0000;
    if (x < XMIN)      c = c | 4'b0001;
    else if (x > XMAX) c = c | 4'b0010;
    if (y < YMIN)      c = c | 4'b0100;
    else if (y > YMAX) c = c | 4'b1000;
    return c;
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive(input int x, input int y, input logic [3:0] e);
    @(negedge clk);
    bus.p.x = 16'(x);
    bus.p.y = 16'(y);
    exp_q.push_back(e);
  endtask

  // Monitor: one result per rising edge while out of reset.
  always @(posedge clk) begin
    #1;
    if (!rst && exp_q.size() > 0) begin
      check("scoreboard", bus.code, exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, queue depth %0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int x;
    int y;
    rst = 1'b0;
    bus.p.x = 16'sd300;
    bus.p.y = 16'sd300;
    #1 rst = 1'b1;
    #1 check("rst_async", bus.code, 4'b0000);

    // Outside point while held in reset: output must stay cleared.
    bus.p.x = 16'sd750;
    bus.p.y = 16'sd560;
    repeat (3) begin
      @(posedge clk);
      #1 check("rst_hold", bus.code, 4'b0000);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(4'b1010);
    #1 check("rst_release_pre_edge", bus.code, 4'b0000);

    foreach (dir_tab[i]) drive(dir_tab[i].x, dir_tab[i].y, dir_tab[i].e);

    // Randomized: half near the window, half over the full 16-bit range.
    for (int i = 0; i < 200; i++) begin
      if (i % 2 == 0) begin
        x = int'($urandom_range(900, 0)) - 130;
        y = int'($urandom_range(700, 0)) - 110;
      end else begin
        x = int'($signed(16'($urandom())));
        y = int'($signed(16'($urandom())));
      end
      drive(x, y, ref_code(x, y));
    end

    // Mid-stream reset while the output shows 1010.
    drive(750, 560, 4'b1010);
    @(posedge clk);
    #3 check("midrst_pre", bus.code, 4'b1010);
    rst = 1'b1;
    #1 check("midrst_async", bus.code, 4'b0000);
    @(posedge clk);
    #1 check("midrst_hold", bus.code, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
